// File: rtl/jaxa_stat_capture_pio.sv
// ---------------------------------------------------------------------------
// jaxa_stat_capture_pio
//
// Avalon-MM slave that captures a bank of statistics input channels.
// Each channel is synchronised into clk, then either snapshotted on command
// (CTRL.SNAP) or loaded continuously (CTRL.LIVE). Per-channel change flags
// (CHG, write-1-to-clear) are gated by MASK into a level interrupt.
//
// Register map (word address):
//   0 .. NUM_CH-1  SNAP_i   R    captured channel value, zero-extended
//   NUM_CH         CHG      R/W1C change flags, one bit per channel
//   NUM_CH+1       MASK     R/W  interrupt enable per channel
//   NUM_CH+2       CTRL     R/W  bit0 SNAP (self-clearing, reads 0), bit1 LIVE
//   NUM_CH+3       SNAPCNT  R    16-bit count of SNAP commands, wraps
//
// Ports:
//   clk        single clock, rising edge
//   reset      asynchronous, active-high reset
//   address    word address
//   read       read strobe (not needed: readdata tracks address every cycle)
//   write      write strobe
//   writedata  write data
//   in_port    channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
//   readdata   registered read data, latency 1
//   irq        registered level interrupt, OR of (CHG & MASK)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module jaxa_stat_capture_pio #(
    parameter int NUM_CH      = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [3:0]                   address,
    input  logic                         read,
    input  logic                         write,
    input  logic [31:0]                  writedata,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_port,
    output logic [31:0]                  readdata,
    output logic                         irq
);

    localparam int W = NUM_CH * DATA_WIDTH;

    localparam logic [3:0] A_CHG  = 4'(NUM_CH);
    localparam logic [3:0] A_MASK = 4'(NUM_CH + 1);
    localparam logic [3:0] A_CTRL = 4'(NUM_CH + 2);
    localparam logic [3:0] A_CNT  = 4'(NUM_CH + 3);

    // read strobe is irrelevant to the read path; upper writedata bits are
    // unused for narrow registers
    logic unused_inputs;
    assign unused_inputs = ^{read, writedata};

    // -----------------------------------------------------------------------
    // Input synchroniser
    // -----------------------------------------------------------------------
    logic [W-1:0] sync_bus;

    generate
        if (SYNC_STAGES == 0) begin : g_bypass
            assign sync_bus = in_port;
        end else begin : g_sync
            logic [W-1:0] stage [SYNC_STAGES];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int s = 0; s < SYNC_STAGES; s++) stage[s] <= '0;
                end else begin
                    stage[0] <= in_port;
                    for (int s = 1; s < SYNC_STAGES; s++) stage[s] <= stage[s-1];
                end
            end

            assign sync_bus = stage[SYNC_STAGES-1];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [W-1:0]          prev;       // sync_bus one cycle earlier
    logic                  armed;      // low for the first cycle after reset
    logic                  snap_pend;  // SNAP written last cycle, load now
    logic                  live;
    logic [NUM_CH-1:0]     chg;
    logic [NUM_CH-1:0]     mask;
    logic [15:0]           snapcnt;
    logic [DATA_WIDTH-1:0] snap [NUM_CH];

    // -----------------------------------------------------------------------
    // Decode and next-state terms
    // -----------------------------------------------------------------------
    logic [NUM_CH-1:0] chg_set;
    logic [NUM_CH-1:0] chg_clr;
    logic              snap_cmd;
    logic [31:0]       rd_next;

    // NOTE: every always_comb output gets a default on entry, so no path
    // through the block can leave a signal unassigned and infer a latch.
    always_comb begin
        chg_set = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            chg_set[i] = armed &&
                (sync_bus[i*DATA_WIDTH +: DATA_WIDTH] != prev[i*DATA_WIDTH +: DATA_WIDTH]);
        end

        chg_clr  = (write && address == A_CHG) ? writedata[NUM_CH-1:0] : '0;
        snap_cmd = write && address == A_CTRL && writedata[0];
    end

    // Read mux; anything not matched below (unmapped) returns zero
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (address == 4'(i)) rd_next[DATA_WIDTH-1:0] = snap[i];
        end
        if (address == A_CHG)  rd_next[NUM_CH-1:0] = chg;
        if (address == A_MASK) rd_next[NUM_CH-1:0] = mask;
        if (address == A_CTRL) rd_next[1]          = live;
        if (address == A_CNT)  rd_next[15:0]       = snapcnt;
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= only, so every flop samples
    // the pre-edge value of its sources regardless of statement order.
    // NOTE: the SNAP array is small and must read 0 straight out of reset,
    // so it is reset like ordinary flops instead of being left as RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev      <= '0;
            armed     <= 1'b0;
            snap_pend <= 1'b0;
            live      <= 1'b0;
            chg       <= '0;
            mask      <= '0;
            snapcnt   <= '0;
            irq       <= 1'b0;
            readdata  <= '0;
            for (int i = 0; i < NUM_CH; i++) snap[i] <= '0;
        end else begin
            armed <= 1'b1;
            prev  <= sync_bus;

            // set has priority over a coincident write-1-to-clear
            chg <= (chg & ~chg_clr) | chg_set;

            if (write && address == A_MASK) mask <= writedata[NUM_CH-1:0];
            if (write && address == A_CTRL) live <= writedata[1];

            snap_pend <= snap_cmd;

            // one load updates every channel in the same edge
            if (snap_pend || live) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    snap[i] <= sync_bus[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end

            // only explicit SNAP commands count, LIVE loads do not
            if (snap_pend) snapcnt <= snapcnt + 16'd1;

            irq      <= |(chg & mask);
            readdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_jaxa_stat_capture_pio.sv
`timescale 1ns/1ps

module tb_jaxa_stat_capture_pio;

    logic         clk = 1'b0;
    logic         reset;

    // main instance: NUM_CH=4, DATA_WIDTH=32, SYNC_STAGES=2
    logic [3:0]   address;
    logic         read;
    logic         write;
    logic [31:0]  writedata;
    logic [127:0] in_port;
    logic [31:0]  readdata;
    logic         irq;

    // narrow instance: NUM_CH=4, DATA_WIDTH=8, synchroniser bypassed
    logic [3:0]   address8;
    logic         read8;
    logic         write8;
    logic [31:0]  writedata8;
    logic [31:0]  in_port8;
    logic [31:0]  readdata8;
    logic         irq8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    jaxa_stat_capture_pio #(.NUM_CH(4), .DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    jaxa_stat_capture_pio #(.NUM_CH(4), .DATA_WIDTH(8), .SYNC_STAGES(0)) dut8 (
        .clk       (clk),
        .reset     (reset),
        .address   (address8),
        .read      (read8),
        .write     (write8),
        .writedata (writedata8),
        .in_port   (in_port8),
        .readdata  (readdata8),
        .irq       (irq8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // inputs change 1ns after the rising edge, outputs are sampled there too
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        tick;
        write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        address = a;
        tick;
        d = readdata;
    endtask

    task automatic wr8(input logic [3:0] a, input logic [31:0] d);
        address8 = a; writedata8 = d; write8 = 1'b1;
        tick;
        write8 = 1'b0;
    endtask

    task automatic rd8(input logic [3:0] a, output logic [31:0] d);
        address8 = a;
        tick;
        d = readdata8;
    endtask

    logic [31:0] v;

    initial begin
        reset = 1'b1;
        address = 4'd0;  read = 1'b0;  write = 1'b0;  writedata = '0;  in_port = '0;
        address8 = 4'd0; read8 = 1'b0; write8 = 1'b0; writedata8 = '0;
        in_port8 = 32'h0000_FF00;          // ch1 = 0xFF, already present in reset

        #2;
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        repeat (3) tick;
        reset = 1'b0;

        // ---- narrow instance: first-cycle suppression, width, unmapped ----
        rd8(4'd4, v);  check("n8_chg_after_release", v, 32'h0);
        wr8(4'd6, 32'h1);
        tick;
        rd8(4'd1, v);  check("n8_snap1_zext", v, 32'h0000_00FF);
        rd8(4'd15, v); check("n8_unmapped_15", v, 32'h0);
        wr8(4'd0, 32'h77);
        rd8(4'd0, v);  check("n8_snap0_ro", v, 32'h0);
        wr8(4'd5, 32'hFFFF_FFFF);
        rd8(4'd5, v);  check("n8_mask_width", v, 32'h0000_000F);
        in_port8 = 32'h0000_FF01;
        tick;
        rd8(4'd4, v);  check("n8_chg_ch0_only", v, 32'h1);

        // ---- main instance: idle state ----
        rd(4'd4, v); check("chg_idle", v, 32'h0);
        rd(4'd7, v); check("snapcnt_idle", v, 32'h0);
        rd(4'd5, v); check("mask_idle", v, 32'h0);

        // ---- snapshot of ch2 ----
        in_port[2*32 +: 32] = 32'h1234_5678;
        repeat (4) tick;
        rd(4'd4, v); check("chg_ch2", v, 32'h4);
        wr(4'd4, 32'hF);
        rd(4'd4, v); check("chg_cleared", v, 32'h0);
        wr(4'd6, 32'h1);
        tick;
        rd(4'd2, v); check("snap2", v, 32'h1234_5678);
        rd(4'd7, v); check("snapcnt_1", v, 32'h1);
        rd(4'd6, v); check("ctrl_snap_reads0", v, 32'h0);

        // ---- hold with LIVE=0, change flag and irq ----
        in_port[0 +: 32] = 32'h0000_00A5;
        repeat (4) tick;
        rd(4'd0, v); check("snap0_held", v, 32'h0);
        rd(4'd4, v); check("chg_ch0", v, 32'h1);
        check("irq_masked", {31'b0, irq}, 32'h0);
        wr(4'd5, 32'h1);
        check("irq_latency", {31'b0, irq}, 32'h0);
        tick;
        check("irq_set", {31'b0, irq}, 32'h1);
        wr(4'd4, 32'h1);
        check("irq_clear_latency", {31'b0, irq}, 32'h1);
        tick;
        check("irq_cleared", {31'b0, irq}, 32'h0);

        // ---- set wins over coincident clear on ch3 ----
        address = 4'd4; writedata = 32'h8; write = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_port[3*32] = ~in_port[3*32];
            tick;
            if (i == 7) begin
                check("chg3_set_wins", readdata, 32'h8);
                check("irq_unmasked_ch3", {31'b0, irq}, 32'h0);
            end
        end
        write = 1'b0;
        repeat (4) tick;
        rd(4'd4, v); check("chg3_held", v, 32'h8);
        wr(4'd4, 32'h8);
        rd(4'd4, v); check("chg3_cleared", v, 32'h0);

        // ---- LIVE mode ----
        wr(4'd6, 32'h2);
        in_port[1*32 +: 32] = 32'h0000_DEAD;
        repeat (4) tick;
        rd(4'd1, v); check("live_snap1", v, 32'h0000_DEAD);
        rd(4'd6, v); check("ctrl_live", v, 32'h2);
        rd(4'd7, v); check("snapcnt_live_nocount", v, 32'h1);
        wr(4'd6, 32'h3);
        tick;
        rd(4'd7, v); check("snapcnt_snap_in_live", v, 32'h2);
        wr(4'd6, 32'h0);
        in_port[1*32 +: 32] = 32'h0000_BEEF;
        repeat (4) tick;
        rd(4'd1, v); check("snap1_hold_after_live", v, 32'h0000_DEAD);

        // ---- unmapped and read-only ----
        rd(4'd15, v); check("unmapped_15", v, 32'h0);
        rd(4'd8, v);  check("unmapped_8", v, 32'h0);
        wr(4'd7, 32'h55);
        rd(4'd7, v);  check("snapcnt_ro", v, 32'h2);
        wr(4'd0, 32'h0);
        rd(4'd0, v);  check("snap0_ro", v, 32'h0000_00A5);

        // ---- SNAPCNT wrap: 2 + 65534 = 0x10000 ----
        address = 4'd6; writedata = 32'h1; write = 1'b1;
        repeat (65534) tick;
        write = 1'b0;
        tick;
        rd(4'd7, v); check("snapcnt_wrap", v, 32'h0);
        wr(4'd6, 32'h1);
        tick;
        rd(4'd7, v); check("snapcnt_after_wrap", v, 32'h1);

        // ---- reset between SNAP write and its load ----
        in_port = '0;
        repeat (4) tick;
        check("irq_pre_reset", {31'b0, irq}, 32'h1);
        rd(4'd7, v); check("readdata_pre_reset", v, 32'h1);
        wr(4'd6, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("abort_readdata", readdata, 32'h0);
        check("abort_irq", {31'b0, irq}, 32'h0);
        repeat (2) tick;
        reset = 1'b0;
        repeat (3) tick;
        for (int a = 0; a < 8; a++) begin
            rd(4'(a), v);
            check($sformatf("post_abort_reg%0d", a), v, 32'h0);
        end
        check("post_abort_irq", {31'b0, irq}, 32'h0);
        rd8(4'd4, v); check("n8_post_abort_chg", v, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/jaxa_stat_capture_pio.md
JAXA_STAT_CAPTURE_PIO -- requirements
Module: jaxa_stat_capture_pio

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- NUM_CH, 4, number of statistics input channels (legal 1..12)
- DATA_WIDTH, 32, width of each channel (legal 1..32)
- SYNC_STAGES, 2, input synchroniser depth (legal 0 = bypass, 2, 3)
REQ-002 Ports SHALL be, one per line: name direction width meaning:
- clk input 1 single clock; all logic on its rising edge
- reset input 1 asynchronous, active-high reset
- address input 4 Avalon-MM slave word address
- read input 1 Avalon-MM read strobe
- write input 1 Avalon-MM write strobe
- writedata input 32 Avalon-MM write data
- in_port input NUM_CH*DATA_WIDTH channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- readdata output 32 registered read data
- irq output 1 registered interrupt, level
REQ-003 Clocking SHALL be one clock (clk); reset SHALL be asynchronous and active-high.

Function
REQ-004 Each channel SHALL pass through SYNC_STAGES flops (sync_i); SYNC_STAGES=0 SHALL use in_port directly.
REQ-005 Register map (word address): 0..NUM_CH-1 SNAP_i (R); NUM_CH CHG (R/W1C); NUM_CH+1 MASK (R/W); NUM_CH+2 CTRL (R/W); NUM_CH+3 SNAPCNT (R).
REQ-006 Reads of unmapped addresses SHALL return 0; writes to them and to read-only registers SHALL be ignored.
REQ-007 readdata SHALL update every cycle from the addressed register (read strobe not required), fixed read latency 1, narrow fields zero-extended to 32 bits.
REQ-008 CTRL bit0 SNAP: a write with bit0=1 SHALL copy all sync_i into SNAP_i in the following cycle, atomically across channels; bit0 SHALL read 0.
REQ-009 CTRL bit1 LIVE: while 1, SNAP_i SHALL load sync_i every cycle; while 0, SNAP_i SHALL hold except on SNAP.
REQ-010 SNAPCNT SHALL be 16 bits, increment by 1 per SNAP command only (not LIVE loads), and wrap 0xFFFF -> 0x0000.
REQ-011 CHG bit i SHALL set when sync_i differs from its value one cycle earlier; bits NUM_CH..31 SHALL read 0.
REQ-012 Writing 1 to a CHG bit SHALL clear it; writing 0 SHALL leave it; if set and clear coincide, set SHALL win.
REQ-013 MASK SHALL be NUM_CH bits; irq SHALL be registered OR of (CHG & MASK), asserting one cycle after the enabling condition.
REQ-014 CHG SHALL not set on the first cycle after reset release (previous-value register loaded, comparison suppressed).
REQ-015 A SNAP write coinciding with LIVE=1 SHALL still increment SNAPCNT.

Reset
REQ-016 On reset assertion, immediately and regardless of clk: readdata=0, irq=0, SNAP_i=0, CHG=0, MASK=0, CTRL=0, SNAPCNT=0, synchroniser and previous-value flops=0.
REQ-017 Reset asserted mid-access SHALL abort it; no register SHALL retain a partial update.

Verification
REQ-018 NUM_CH=4, DATA_WIDTH=32: drive ch2=0x12345678, write CTRL=1 -> after SYNC_STAGES+2 cycles read addr 2 = 0x12345678, SNAPCNT=1.
REQ-019 LIVE=0, change ch0 after SNAP -> SNAP_0 unchanged, CHG=0x1; MASK=0x1 -> irq=1 next cycle; write CHG=0x1 -> irq=0 two cycles later.
REQ-020 Toggle ch3 every cycle while writing CHG=0x8 every cycle -> CHG[3] stays 1 (set wins).
REQ-021 Issue 65536 SNAP writes -> SNAPCNT=0x0000; one more -> 0x0001.
REQ-022 DATA_WIDTH=8, in ch1=0xFF -> SNAP_1 reads 0x000000FF; read address 15 -> 0; write to address 0 -> SNAP_0 unchanged.
REQ-023 Assert reset between SNAP write and its load cycle -> all registers 0, SNAPCNT=0, irq=0, no change flags after release.
